// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU operand sequencer
package alu_seq_pkg;

  // Sequencer states; EXEC and HOLD share one external stage code
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // Operation select codes understood by the downstream logic mux
  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_CORR_R = 3'd3;
  localparam logic [2:0] OP_CORR_I = 3'd4;
  localparam logic [2:0] OP_CORR_C = 3'd5;
  localparam logic [2:0] OP_RSVD6  = 3'd6;
  localparam logic [2:0] OP_RSVD7  = 3'd7;

  // External stage encoding
  localparam logic [1:0] STAGE_WAIT_A  = 2'd0;
  localparam logic [1:0] STAGE_WAIT_B  = 2'd1;
  localparam logic [1:0] STAGE_WAIT_OP = 2'd2;
  localparam logic [1:0] STAGE_EXEC    = 2'd3;

  // Reserved codes alias to AND in the mux and may be rejected at load time
  function automatic logic is_reserved_sel(input logic [2:0] sel);
    return (sel == OP_RSVD6) || (sel == OP_RSVD7);
  endfunction

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - W-bit register with async reset, sync clear and load enable
module en_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear takes priority over enable so an abort always zeroes the value
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - loads A, B and select from one bus, captures mux result (option: OPSEQ_SEL_CHECK_EN)
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [N-1:0] data_in,
  input  logic [2:0]   sel_in,
  input  logic [N-1:0] result_in,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [2:0]   s,
  output logic [1:0]   stage,
  output logic         op_valid,
  output logic [N-1:0] result_q,
  output logic         zero,
  output logic         sel_err
);

  state_t state, next_state;
  logic   sel_ok;
  logic   en_a, en_b, en_s, en_res;
  logic   reject;

`ifdef OPSEQ_SEL_CHECK_EN
  assign sel_ok = !is_reserved_sel(sel_in);
`else
  assign sel_ok = 1'b1;
`endif

  // A load in WAIT_OP with a refused select is only meaningful with checking on
  assign reject = load && !clear && (state == WAIT_OP) && !sel_ok;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_A;
    else     state <= next_state;
  end

  // Next-state and register-enable decode; clear overrides any load
  always_comb begin
    next_state = state;
    en_a       = 1'b0;
    en_b       = 1'b0;
    en_s       = 1'b0;
    en_res     = 1'b0;
    if (clear) begin
      next_state = WAIT_A;
    end else begin
      case (state)
        WAIT_A: if (load) begin
          en_a       = 1'b1;
          next_state = WAIT_B;
        end
        WAIT_B: if (load) begin
          en_b       = 1'b1;
          next_state = WAIT_OP;
        end
        WAIT_OP: if (load && sel_ok) begin
          en_s       = 1'b1;
          next_state = EXEC;
        end
        EXEC: begin
          en_res     = 1'b1;
          next_state = HOLD;
        end
        HOLD: if (load) begin
          en_a       = 1'b1;
          next_state = WAIT_B;
        end
        default: next_state = WAIT_A;
      endcase
    end
  end

  en_reg #(.W(N)) u_reg_a (
    .clk(clk), .rst(rst), .clr(clear), .en(en_a), .d(data_in), .q(A)
  );

  en_reg #(.W(N)) u_reg_b (
    .clk(clk), .rst(rst), .clr(clear), .en(en_b), .d(data_in), .q(B)
  );

  en_reg #(.W(3)) u_reg_s (
    .clk(clk), .rst(rst), .clr(clear), .en(en_s), .d(sel_in), .q(s)
  );

  en_reg #(.W(N)) u_reg_res (
    .clk(clk), .rst(rst), .clr(clear), .en(en_res), .d(result_in), .q(result_q)
  );

  // Zero flag tracks result_q; an empty result register reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         zero <= 1'b1;
    else if (clear)  zero <= 1'b1;
    else if (en_res) zero <= (result_in == '0);
  end

`ifdef OPSEQ_SEL_CHECK_EN
  // One-cycle pulse following each refused select load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err <= 1'b0;
    else     sel_err <= reject;
  end
`else
  assign sel_err = 1'b0;
`endif

  // Stage and op_valid derive from the state register only
  always_comb begin
    stage    = STAGE_WAIT_A;
    op_valid = 1'b0;
    case (state)
      WAIT_A:  stage = STAGE_WAIT_A;
      WAIT_B:  stage = STAGE_WAIT_B;
      WAIT_OP: stage = STAGE_WAIT_OP;
      EXEC: begin
        stage    = STAGE_EXEC;
        op_valid = 1'b1;
      end
      HOLD:    stage = STAGE_EXEC;
      default: stage = STAGE_WAIT_A;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer (honours OPSEQ_SEL_CHECK_EN)
module tb_alu_operand_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         clear = 1'b0;
  logic [N-1:0] data_in = '0;
  logic [2:0]   sel_in = '0;
  logic [N-1:0] result_in;
  logic [N-1:0] A, B, result_q;
  logic [2:0]   s;
  logic [1:0]   stage;
  logic         op_valid, zero, sel_err;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase 0..4 = wait A, wait B, wait op, exec, hold
  int           m_phase;
  logic [N-1:0] m_a, m_b, m_res;
  logic [2:0]   m_s;
  logic         m_zero, m_err;

  alu_operand_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .load(load), .clear(clear), .data_in(data_in),
    .sel_in(sel_in), .result_in(result_in), .A(A), .B(B), .s(s),
    .stage(stage), .op_valid(op_valid), .result_q(result_q), .zero(zero),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Behavioural logic mux
  function automatic logic [N-1:0] mux_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] sel);
    case (sel)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~a & b;
      3'd5:    return a & ~b;
      default: return a & b;
    endcase
  endfunction

  assign result_in = mux_op(A, B, s);

  function automatic bit sel_rejected(input logic [2:0] sel);
`ifdef OPSEQ_SEL_CHECK_EN
    return sel >= 3'd6;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_s = '0; m_res = '0; m_zero = 1'b1; m_err = 1'b0;
  endtask

  // Drive one clock cycle of stimulus from a negedge, advance the model, return at next negedge
  task automatic step(input bit ld, input bit clr, input logic [N-1:0] d, input logic [2:0] sel);
    load = ld; clear = clr; data_in = d; sel_in = sel;
    m_err = 1'b0;
    if (clr) begin
      m_phase = 0; m_a = '0; m_b = '0; m_s = '0; m_res = '0; m_zero = 1'b1;
    end else begin
      case (m_phase)
        0: if (ld) begin m_a = d; m_phase = 1; end
        1: if (ld) begin m_b = d; m_phase = 2; end
        2: if (ld) begin
             if (sel_rejected(sel)) m_err = 1'b1;
             else begin m_s = sel; m_phase = 3; end
           end
        3: begin m_res = mux_op(m_a, m_b, m_s); m_zero = (m_res == 0); m_phase = 4; end
        default: if (ld) begin m_a = d; m_phase = 1; end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_total++; if (stage !== 2'd0) $display("FAIL reset_stage actual=%0d required=0", stage); else n_pass++;
    n_total++; if ({A, B, s, result_q} !== '0) $display("FAIL reset_regs actual=%h required=0", {A, B, s, result_q}); else n_pass++;
    n_total++; if ({zero, op_valid, sel_err} !== 3'b100) $display("FAIL reset_flags actual=%b required=100", {zero, op_valid, sel_err}); else n_pass++;
  endtask

  task automatic test_basic_and();
    step(1, 0, 4'hA, 3'd0);
    step(1, 0, 4'h6, 3'd0);
    step(1, 0, 4'h0, 3'd0);
    n_total++; if ({A, B, s} !== {4'hA, 4'h6, 3'd0}) $display("FAIL and_operands actual=%h required=%h", {A, B, s}, {4'hA, 4'h6, 3'd0}); else n_pass++;
    n_total++; if (op_valid !== 1'b1 || stage !== 2'd3) $display("FAIL and_exec actual=%b/%0d required=1/3", op_valid, stage); else n_pass++;
    step(0, 0, 4'h0, 3'd0);
    n_total++; if (op_valid !== 1'b0) $display("FAIL and_op_valid_width actual=%b required=0", op_valid); else n_pass++;
    n_total++; if (result_q !== 4'h2 || zero !== 1'b0 || stage !== 2'd3) $display("FAIL and_result actual=%h/%b/%0d required=2/0/3", result_q, zero, stage); else n_pass++;
  endtask

  task automatic test_zero_flag();
    step(1, 0, 4'h5, 3'd0);
    step(1, 0, 4'hA, 3'd0);
    step(1, 0, 4'h0, 3'd0);
    step(0, 0, 4'h0, 3'd0);
    n_total++; if (result_q !== 4'h0 || zero !== 1'b1) $display("FAIL zero_and actual=%h/%b required=0/1", result_q, zero); else n_pass++;
    step(1, 0, 4'h5, 3'd0);
    step(1, 0, 4'hA, 3'd0);
    step(1, 0, 4'h0, 3'd1);
    step(0, 0, 4'h0, 3'd0);
    n_total++; if (result_q !== 4'hF || zero !== 1'b0) $display("FAIL zero_or actual=%h/%b required=f/0", result_q, zero); else n_pass++;
  endtask

  task automatic test_fast_reentry();
    step(1, 0, 4'h3, 3'd0);
    n_total++; if (A !== 4'h3 || stage !== 2'd1 || B !== 4'hA) $display("FAIL reentry_load actual=%h/%0d/%h required=3/1/a", A, stage, B); else n_pass++;
    n_total++; if (result_q !== 4'hF || s !== 3'd1) $display("FAIL reentry_retained actual=%h/%0d required=f/1", result_q, s); else n_pass++;
    step(1, 0, 4'h3, 3'd0);
    step(1, 0, 4'h0, 3'd2);
    step(0, 0, 4'h0, 3'd0);
    n_total++; if (result_q !== 4'h0 || zero !== 1'b1) $display("FAIL reentry_xor actual=%h/%b required=0/1", result_q, zero); else n_pass++;
  endtask

  task automatic test_clear_priority();
    step(1, 0, 4'h1, 3'd0);
    step(1, 0, 4'h2, 3'd0);
    step(1, 1, 4'h7, 3'd3);
    n_total++; if (stage !== 2'd0 || {A, B, s} !== '0) $display("FAIL clear_regs actual=%0d/%h required=0/0", stage, {A, B, s}); else n_pass++;
    n_total++; if (zero !== 1'b1 || result_q !== 4'h0 || op_valid !== 1'b0) $display("FAIL clear_flags actual=%b/%h/%b required=1/0/0", zero, result_q, op_valid); else n_pass++;
  endtask

  task automatic test_exec_load_ignored();
    step(1, 0, 4'h4, 3'd0);
    step(1, 0, 4'h5, 3'd0);
    step(1, 0, 4'h0, 3'd1);
    step(1, 0, 4'hF, 3'd0);
    n_total++; if (stage !== 2'd3 || op_valid !== 1'b0 || A !== 4'h4) $display("FAIL exec_ignore actual=%0d/%b/%h required=3/0/4", stage, op_valid, A); else n_pass++;
    n_total++; if (result_q !== 4'h5 || zero !== 1'b0) $display("FAIL exec_result actual=%h/%b required=5/0", result_q, zero); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1, 0, 4'h9, 3'd0);
    n_total++; if (A !== 4'h9 || stage !== 2'd1) $display("FAIL async_pre actual=%h/%0d required=9/1", A, stage); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (A !== 4'h0 || stage !== 2'd0 || zero !== 1'b1) $display("FAIL async_reset actual=%h/%0d/%b required=0/0/1", A, stage, zero); else n_pass++;
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_sel_check();
    step(1, 0, 4'hC, 3'd0);
    step(1, 0, 4'h3, 3'd0);
    step(1, 0, 4'h0, 3'd7);
`ifdef OPSEQ_SEL_CHECK_EN
    n_total++; if (sel_err !== 1'b1 || stage !== 2'd2 || s !== 3'd0) $display("FAIL sel_reject actual=%b/%0d/%0d required=1/2/0", sel_err, stage, s); else n_pass++;
    step(0, 0, 4'h0, 3'd0);
    n_total++; if (sel_err !== 1'b0 || stage !== 2'd2) $display("FAIL sel_pulse actual=%b/%0d required=0/2", sel_err, stage); else n_pass++;
    step(1, 0, 4'h0, 3'd1);
    n_total++; if (stage !== 2'd3 || s !== 3'd1 || sel_err !== 1'b0) $display("FAIL sel_accept actual=%0d/%0d/%b required=3/1/0", stage, s, sel_err); else n_pass++;
`else
    n_total++; if (stage !== 2'd3 || s !== 3'd7 || sel_err !== 1'b0) $display("FAIL sel_accept7 actual=%0d/%0d/%b required=3/7/0", stage, s, sel_err); else n_pass++;
`endif
    step(0, 0, 4'h0, 3'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit           ld, clr;
      logic [N-1:0] d;
      logic [2:0]   sel;
      logic [1:0]   exp_stage;
      ld  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      d   = N'($urandom);
      sel = 3'($urandom);
      step(ld, clr, d, sel);
      exp_stage = (m_phase >= 3) ? 2'd3 : 2'(m_phase);
      n_total++;
      if ({A, B, s, result_q} !== {m_a, m_b, m_s, m_res} || stage !== exp_stage ||
          op_valid !== (m_phase == 3) || zero !== m_zero || sel_err !== m_err)
        $display("FAIL random_%0d actual=%h/%h/%0d/%h st=%0d v=%b z=%b e=%b required=%h/%h/%0d/%h st=%0d v=%b z=%b e=%b",
                 i, A, B, s, result_q, stage, op_valid, zero, sel_err,
                 m_a, m_b, m_s, m_res, exp_stage, (m_phase == 3), m_zero, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_and();
    test_zero_flag();
    test_fast_reentry();
    test_clear_priority();
    test_exec_load_ignored();
    test_async_reset();
    test_sel_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
